ibis_texture_mapper_pipe: RTL and testbench

Fully pipelined affine texture-address generator. It maps screen coordinates (x, y) through a 2×2 fixed-point matrix plus translation into a tile-local texel address, and accepts one pixel per clock under valid/ready flow control. Matrix updates are double-buffered and committed atomically between pixels. It sits between the span rasteriser and the texture-tile RAM, replacing the 10-cycle round-robin mapper.

---
 rtl/ibis_texture_mapper_pipe_if.sv | 36 +++
 rtl/ibis_texture_mapper_pipe.sv | 161 ++++++++++++++++
 tb/tb_ibis_texture_mapper_pipe.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibis_texture_mapper_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibis_texture_mapper_pipe_if: config, pixel-in and address-out bundle       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ibis_texture_mapper_pipe_if #(
  parameter int TILE_SIZE_POW2 = 5,
  parameter int WIDTH          = 10,
  parameter int COEF_WIDTH     = 12
);
  logic                           cfg_valid;
  logic [2:0]                     cfg_index;
  logic signed [COEF_WIDTH-1:0]   cfg_data;
  logic                           cfg_busy;

  logic                           s_valid;
  logic                           s_ready;
  logic [WIDTH-1:0]               s_x;
  logic [WIDTH-1:0]               s_y;

  logic                           m_valid;
  logic                           m_ready;
  logic [2*TILE_SIZE_POW2-1:0]    m_address;
  logic                           m_stencil;

  modport master (
    output cfg_valid, cfg_index, cfg_data, s_valid, s_x, s_y, m_ready,
    input  cfg_busy, s_ready, m_valid, m_address, m_stencil
  );

  modport slave (
    input  cfg_valid, cfg_index, cfg_data, s_valid, s_x, s_y, m_ready,
    output cfg_busy, s_ready, m_valid, m_address, m_stencil
  );
endinterface
`default_nettype wire

// File: rtl/ibis_texture_mapper_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibis_texture_mapper_pipe: 3-stage affine screen->texel address generator   |
// | Optional wrap addressing: define IBIS_TEXMAP_WRAP_EN.     Rev 1.0          |
// +----------------------------------------------------------------------------+
module ibis_texture_mapper_pipe #(
  parameter int TILE_SIZE_POW2 = 5,
  parameter int WIDTH          = 10,
  parameter int COEF_WIDTH     = 12,
  parameter int FRAC_BITS      = 4
) (
  input  wire                       aclk,
  input  wire                       aresetn,
  ibis_texture_mapper_pipe_if.slave bus
);

  localparam int ACC_W = COEF_WIDTH + WIDTH + 2;
  localparam int T     = TILE_SIZE_POW2;
  localparam logic signed [COEF_WIDTH-1:0] ONE = COEF_WIDTH'(1 << FRAC_BITS);

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [COEF_WIDTH-1:0] c);
    return ACC_W'(c);
  endfunction

  logic signed [COEF_WIDTH-1:0] sh_a, sh_b, sh_c, sh_d, sh_tx, sh_ty;
  logic signed [COEF_WIDTH-1:0] act_a, act_b, act_c, act_d, act_tx, act_ty;
  logic                         commit_pending;

  logic                         v1, v2;
  logic signed [ACC_W-1:0]      p_ax, p_by, p_cx, p_dy;
  logic signed [ACC_W-1:0]      sum_x, sum_y;

  logic                         advance;
  logic                         s_ready_int;
  logic                         accept;
  logic                         commit_fire;
  logic signed [ACC_W-1:0]      x_ext, y_ext;
  logic signed [ACC_W-1:0]      u_full, v_full;
  logic                         in_u, in_v, pass_u, pass_v;

  assign advance     = !bus.m_valid || bus.m_ready;
  assign s_ready_int = advance && !commit_pending && aresetn;
  assign accept      = bus.s_valid && s_ready_int;
  // The active bank may only change once nothing in flight depends on it
  assign commit_fire = commit_pending && !v1 && !v2 && !bus.m_valid;

  assign bus.s_ready  = s_ready_int;
  assign bus.cfg_busy = commit_pending;

  assign x_ext = signed'(ACC_W'(bus.s_x));
  assign y_ext = signed'(ACC_W'(bus.s_y));

  // Shadow bank writes and atomic shadow->active copy
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sh_a   <= ONE;
      sh_b   <= '0;
      sh_c   <= '0;
      sh_d   <= ONE;
      sh_tx  <= '0;
      sh_ty  <= '0;
      act_a  <= ONE;
      act_b  <= '0;
      act_c  <= '0;
      act_d  <= ONE;
      act_tx <= '0;
      act_ty <= '0;
    end else begin
      if (bus.cfg_valid) begin
        case (bus.cfg_index)
          3'd0:    sh_a  <= bus.cfg_data;
          3'd1:    sh_b  <= bus.cfg_data;
          3'd2:    sh_c  <= bus.cfg_data;
          3'd3:    sh_d  <= bus.cfg_data;
          3'd4:    sh_tx <= bus.cfg_data;
          3'd5:    sh_ty <= bus.cfg_data;
          default: ;
        endcase
      end
      if (commit_fire) begin
        act_a  <= sh_a;
        act_b  <= sh_b;
        act_c  <= sh_c;
        act_d  <= sh_d;
        act_tx <= sh_tx;
        act_ty <= sh_ty;
      end
    end
  end

  // A repeated commit while one is pending is simply absorbed
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      commit_pending <= 1'b0;
    end else if (commit_pending) begin
      if (commit_fire) commit_pending <= 1'b0;
    end else if (bus.cfg_valid && bus.cfg_index == 3'd7) begin
      commit_pending <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (advance) begin
      if (accept) begin
        p_ax <= sext(act_a) * x_ext;
        p_by <= sext(act_b) * y_ext;
        p_cx <= sext(act_c) * x_ext;
        p_dy <= sext(act_d) * y_ext;
      end
      if (v1) begin
        sum_x <= p_ax + p_by - (sext(act_tx) <<< FRAC_BITS);
        sum_y <= p_cx + p_dy - (sext(act_ty) <<< FRAC_BITS);
      end
    end
  end

  assign u_full = sum_x >>> FRAC_BITS;
  assign v_full = sum_y >>> FRAC_BITS;
  assign in_u   = (u_full[ACC_W-1:T] == '0);
  assign in_v   = (v_full[ACC_W-1:T] == '0);

`ifdef IBIS_TEXMAP_WRAP_EN
  logic [1:0] sh_wrap, act_wrap;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sh_wrap  <= 2'b00;
      act_wrap <= 2'b00;
    end else begin
      if (bus.cfg_valid && bus.cfg_index == 3'd6) sh_wrap <= bus.cfg_data[1:0];
      if (commit_fire) act_wrap <= sh_wrap;
    end
  end

  assign pass_u = in_u || act_wrap[0];
  assign pass_v = in_v || act_wrap[1];
`else
  assign pass_u = in_u;
  assign pass_v = in_v;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.m_valid   <= 1'b0;
      bus.m_address <= '0;
      bus.m_stencil <= 1'b0;
    end else if (advance) begin
      v1          <= accept;
      v2          <= v1;
      bus.m_valid <= v2;
      if (v2) begin
        bus.m_address <= {v_full[T-1:0], u_full[T-1:0]};
        bus.m_stencil <= pass_u && pass_v;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibis_texture_mapper_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ibis_texture_mapper_pipe: randomized + directed bench with ref model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ibis_texture_mapper_pipe;
  localparam int T   = 5;
  localparam int W   = 10;
  localparam int CW  = 12;
  localparam int F   = 4;
  localparam int ONE = 1 << F;
  localparam int TS  = 1 << T;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ibis_texture_mapper_pipe_if #(.TILE_SIZE_POW2(T), .WIDTH(W), .COEF_WIDTH(CW)) bus ();

  ibis_texture_mapper_pipe #(
    .TILE_SIZE_POW2(T), .WIDTH(W), .COEF_WIDTH(CW), .FRAC_BITS(F)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int out_count = 0;

  // Reference matrix: shadow and active copies as plain integers
  int ma, mb, mc, md, mtx, mty, mw;
  int sa, sb, sc, sd, stx, sty, sw;
  logic [2*T:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [2*T-1:0] prev_addr;
  logic         prev_st;

  function automatic void model_reset();
    ma = ONE; mb = 0; mc = 0; md = ONE; mtx = 0; mty = 0; mw = 0;
    sa = ONE; sb = 0; sc = 0; sd = ONE; stx = 0; sty = 0; sw = 0;
  endfunction

  function automatic int floor_div(int n, int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int mod_t(int u);
    return ((u % TS) + TS) % TS;
  endfunction

  function automatic logic [2*T:0] ref_pix(int x, int y);
    int xp, yp, u, v;
    bit su, sv;
    xp = ma * x + mb * y - mtx * ONE;
    yp = mc * x + md * y - mty * ONE;
    u  = floor_div(xp, ONE);
    v  = floor_div(yp, ONE);
    su = (u >= 0) && (u < TS);
    sv = (v >= 0) && (v < TS);
`ifdef IBIS_TEXMAP_WRAP_EN
    if (mw % 2 == 1) su = 1'b1;
    if (mw / 2 == 1) sv = 1'b1;
`endif
    return {(su && sv) ? 1'b1 : 1'b0, (2*T)'(mod_t(v) * TS + mod_t(u))};
  endfunction

  function automatic void model_cfg(int idx, int d);
    case (idx)
      0: sa = d;
      1: sb = d;
      2: sc = d;
      3: sd = d;
      4: stx = d;
      5: sty = d;
`ifdef IBIS_TEXMAP_WRAP_EN
      6: sw = d & 3;
`endif
      7: begin
        ma = sa; mb = sb; mc = sc; md = sd; mtx = stx; mty = sty; mw = sw;
      end
      default: ;
    endcase
  endfunction

  // Scoreboard: pixels accepted before a commit use the matrix in force then
  always @(negedge aclk) begin : scoreboard
    logic [2*T:0] e;
    if (!aresetn) begin
      exp_q.delete();
      model_reset();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_address !== prev_addr || bus.m_stencil !== prev_st) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b addr=%0d st=%0b, required valid=1 addr=%0d st=%0b",
                   bus.m_valid, bus.m_address, bus.m_stencil, prev_addr, prev_st);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        checks++;
        out_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: addr=%0d st=%0b, required no output",
                   bus.m_address, bus.m_stencil);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_stencil, bus.m_address} !== e) begin
            errors++;
            $display("FAIL scoreboard: addr=%0d st=%0b, required addr=%0d st=%0b",
                     bus.m_address, bus.m_stencil, e[2*T-1:0], e[2*T]);
          end
        end
      end
      stall_prev = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
      prev_addr  = bus.m_address;
      prev_st    = bus.m_stencil;
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1)
        exp_q.push_back(ref_pix(int'(bus.s_x), int'(bus.s_y)));
      if (bus.cfg_valid === 1'b1)
        model_cfg(int'(bus.cfg_index), int'($signed(bus.cfg_data)));
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int data);
    bus.cfg_valid = 1'b1;
    bus.cfg_index = 3'(idx);
    bus.cfg_data  = CW'(data);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (bus.cfg_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL commit_timeout: cfg_busy=%0b, required 0", bus.cfg_busy);
    end
  endtask

  task automatic commit();
    cfg_write(7, 0);
    wait_not_busy();
  endtask

  task automatic send_pixel(input int x, input int y);
    bit acc = 1'b0;
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_x     = W'(x);
    bus.s_y     = W'(y);
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = (bus.s_ready === 1'b1);
      tick();
      n++;
    end
    bus.s_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready never rose, required acceptance");
    end
  endtask

  task automatic wait_output(output logic [2*T-1:0] a, output logic s, output int lat);
    bit found = 1'b0;
    lat = -1;
    a = '0;
    s = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge aclk);
      if (bus.m_valid === 1'b1) begin
        found = 1'b1;
        a = bus.m_address;
        s = bus.m_stencil;
        lat = n + 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.cfg_valid = 1'b0; bus.cfg_index = '0; bus.cfg_data = '0;
    bus.s_valid = 1'b0; bus.s_x = '0; bus.s_y = '0; bus.m_ready = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks += 5;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: %0b, required 0", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: %0b, required 0", bus.m_valid); end
    if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: %0b, required 0", bus.cfg_busy); end
    if (bus.m_address !== '0) begin errors++; $display("FAIL reset_m_address: %0d, required 0", bus.m_address); end
    if (bus.m_stencil !== 1'b0) begin errors++; $display("FAIL reset_m_stencil: %0b, required 0", bus.m_stencil); end
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: %0b, required 1", bus.s_ready); end
    tick();
  endtask

  task automatic test_identity();
    logic [2*T-1:0] a; logic s; int lat;
    send_pixel(3, 5);
    wait_output(a, s, lat);
    checks += 3;
    if (lat != 3) begin errors++; $display("FAIL identity_latency: %0d, required 3", lat); end
    if (a !== 10'd163) begin errors++; $display("FAIL identity_addr: %0d, required 163", a); end
    if (s !== 1'b1) begin errors++; $display("FAIL identity_stencil: %0b, required 1", s); end
  endtask

  task automatic test_translation();
    logic [2*T-1:0] a; logic s; int lat;
    cfg_write(4, 10);
    commit();
    send_pixel(3, 5);
    wait_output(a, s, lat);
    checks += 3;
    if (s !== 1'b0) begin errors++; $display("FAIL translate_stencil: %0b, required 0", s); end
    if (a[4:0] !== 5'd25) begin errors++; $display("FAIL translate_u: %0d, required 25", a[4:0]); end
    if (a !== 10'd185) begin errors++; $display("FAIL translate_addr: %0d, required 185", a); end
  endtask

  task automatic test_scale_wrap();
    logic [2*T-1:0] a; logic s; int lat;
    cfg_write(4, 0);
    cfg_write(0, 'h20);
    commit();
    send_pixel(20, 0);
    wait_output(a, s, lat);
    checks += 2;
    if (s !== 1'b0) begin errors++; $display("FAIL scale_stencil: %0b, required 0", s); end
    if (a !== 10'd8) begin errors++; $display("FAIL scale_addr: %0d, required 8", a); end
    cfg_write(6, 1);
    commit();
    send_pixel(20, 0);
    wait_output(a, s, lat);
    checks += 2;
`ifdef IBIS_TEXMAP_WRAP_EN
    if (s !== 1'b1) begin errors++; $display("FAIL wrap_stencil: %0b, required 1", s); end
`else
    if (s !== 1'b0) begin errors++; $display("FAIL nowrap_stencil: %0b, required 0", s); end
`endif
    if (a !== 10'd8) begin errors++; $display("FAIL wrap_addr: %0d, required 8", a); end
    cfg_write(0, ONE);
    cfg_write(6, 0);
    commit();
  endtask

  task automatic test_back_to_back();
    int c0 = out_count;
    bus.m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_pixel(i * 3 + 1, i + 2);
      end
      begin
        repeat (4) tick();
        bus.m_ready = 1'b0;
        @(negedge aclk);
        checks += 2;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid: %0b, required 1", bus.m_valid); end
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready: %0b, required 0", bus.s_ready); end
        repeat (4) tick();
        bus.m_ready = 1'b1;
      end
    join
    repeat (6) tick();
    checks += 2;
    if (out_count - c0 != 8) begin errors++; $display("FAIL b2b_count: %0d, required 8", out_count - c0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_commit_full();
    logic [2*T-1:0] a; logic s; int lat;
    int c0 = out_count;
    int n = 0;
    bus.m_ready = 1'b1;
    cfg_write(1, ONE);
    send_pixel(1, 2);
    send_pixel(3, 4);
    send_pixel(5, 6);
    cfg_write(7, 0);
    checks += 2;
    if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL commit_busy: %0b, required 1", bus.cfg_busy); end
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL commit_s_ready: %0b, required 0", bus.s_ready); end
    cfg_write(7, 0);
    while (bus.cfg_busy === 1'b1 && n < 50) begin
      checks++;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL busy_s_ready: %0b, required 0", bus.s_ready); end
      tick();
      n++;
    end
    checks += 2;
    if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL commit_drain: cfg_busy=%0b, required 0", bus.cfg_busy); end
    if (out_count - c0 != 3) begin errors++; $display("FAIL commit_old_count: %0d, required 3", out_count - c0); end
    send_pixel(1, 2);
    wait_output(a, s, lat);
    checks += 2;
    if (a !== 10'd67) begin errors++; $display("FAIL commit_new_addr: %0d, required 67", a); end
    if (s !== 1'b1) begin errors++; $display("FAIL commit_new_stencil: %0b, required 1", s); end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int r = 0; r < 4; r++) begin
          cfg_write(0, int'($urandom_range(0, 96)) - 48);
          cfg_write(1, int'($urandom_range(0, 96)) - 48);
          cfg_write(2, int'($urandom_range(0, 96)) - 48);
          cfg_write(3, int'($urandom_range(0, 96)) - 48);
          cfg_write(4, int'($urandom_range(0, 200)) - 100);
          cfg_write(5, int'($urandom_range(0, 200)) - 100);
          cfg_write(6, int'($urandom_range(0, 3)));
          commit();
          for (int k = 0; k < 40; k++) begin
            int x = int'($urandom_range(0, 63));
            int y = int'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) x = 1023;
            if ($urandom_range(0, 7) == 0) y = 1023;
            send_pixel(x, y);
            if ($urandom_range(0, 3) == 0) tick();
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          bus.m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.m_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_pending: %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [2*T-1:0] a; logic s; int lat;
    cfg_write(0, 32);
    cfg_write(1, 0);
    cfg_write(2, 0);
    cfg_write(3, ONE);
    cfg_write(4, 0);
    cfg_write(5, 0);
    cfg_write(6, 0);
    commit();
    bus.m_ready = 1'b0;
    send_pixel(1, 1);
    send_pixel(2, 2);
    cfg_write(7, 0);
    checks++;
    if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL midreset_pending: %0b, required 1", bus.cfg_busy); end
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    checks += 2;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midreset_m_valid: %0b, required 0", bus.m_valid); end
    if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL midreset_cfg_busy: %0b, required 0", bus.cfg_busy); end
    tick();
    aresetn = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: m_valid=%0b, required 0", bus.m_valid); end
    end
    send_pixel(3, 5);
    wait_output(a, s, lat);
    checks += 2;
    if (a !== 10'd163) begin errors++; $display("FAIL midreset_identity_addr: %0d, required 163", a); end
    if (s !== 1'b1) begin errors++; $display("FAIL midreset_identity_stencil: %0b, required 1", s); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_identity();
    test_translation();
    test_scale_wrap();
    test_back_to_back();
    test_commit_full();
    test_random();
    test_reset_mid();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending: %0d, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
